// File: rtl/vdrive_linebuf.sv
// Double-buffered scanline fetcher: copies one VRAM row per line into a back buffer and scales the front buffer onto the beam.
// Optional border colour outside the playfield window is enabled with macro VDRIVE_BORDER_EN.
module vdrive_linebuf #(
    parameter int PLANES = 2,
    parameter int H_END  = 256,
    parameter int V_OFS  = 56,
    parameter int BORDER = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hires,
    input  logic [8:0]        hvsync_hpos,
    input  logic [8:0]        hvsync_vpos,
    input  logic              display_on,
    output logic [6:0]        vram_hpos,
    output logic [5:0]        vram_vpos,
    input  logic [PLANES-1:0] vram_pixel,
    output logic [PLANES-1:0] hvsync_pixel,
    output logic              fetch_busy,
    output logic              underrun
);

`ifdef VDRIVE_BORDER_EN
    localparam logic BORDER_ON = 1'b1;
`else
    localparam logic BORDER_ON = 1'b0;
`endif

    localparam logic [PLANES-1:0] OUTSIDE_PIX = PLANES'(BORDER) & {PLANES{BORDER_ON}};
    localparam logic [9:0]        WIN_LO      = 10'(V_OFS);
    localparam logic [9:0]        WIN_HI      = 10'(V_OFS + 127);
    localparam logic [8:0]        H_SWAP      = 9'(H_END);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        col_q, col_d;
    logic [5:0]        row_q, row_d;
    logic              mode_q;
    logic              front_q;
    logic [1:0]        valid_q, valid_d;
    logic              underrun_q;
    logic              wr_en_q;
    logic [6:0]        wr_col_q;
    logic [PLANES-1:0] pix_q, pix_d;
    logic [PLANES-1:0] buf_mem [0:1][0:127];

    logic [9:0] vpos_n;
    logic [6:0] rel;
    logic [5:0] row_fetch;
    logic [6:0] last_col;
    logic [6:0] rd_idx;
    logic       trig, swap, in_win_v, done, abort;

    assign vpos_n    = {1'b0, hvsync_vpos} + 10'd1;
    // Only the low 7 bits of (vpos+1-V_OFS) matter inside the 128-line window.
    assign rel       = vpos_n[6:0] - WIN_LO[6:0];
    assign row_fetch = mode_q ? rel[6:1] : {1'b0, rel[6:2]};
    assign trig      = (hvsync_hpos == 9'd0) && (vpos_n >= WIN_LO) && (vpos_n <= WIN_HI);
    assign swap      = (hvsync_hpos == H_SWAP);
    assign in_win_v  = ({1'b0, hvsync_vpos} >= WIN_LO) && ({1'b0, hvsync_vpos} <= WIN_HI);
    assign last_col  = mode_q ? 7'd127 : 7'd63;
    assign rd_idx    = mode_q ? hvsync_hpos[7:1] : {1'b0, hvsync_hpos[7:2]};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = FETCH;
                    col_d   = 7'd0;
                    row_d   = row_fetch;
                end
            end
            FETCH: begin
                if (col_q == last_col) begin
                    state_d = DRAIN;
                    col_d   = 7'd0;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A swap while the fetch is still running wins: the half-filled buffer stays invalid.
        if (swap && (state_q != IDLE)) begin
            state_d = IDLE;
            col_d   = 7'd0;
            done    = 1'b0;
            abort   = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (done) begin
            valid_d[~front_q] = 1'b1;
        end
        if (swap) begin
            valid_d[front_q] = 1'b0;
        end
    end

    // hpos < N<<s reduces to hpos < 256 in both modes.
    always_comb begin
        pix_d = '0;
        if (display_on) begin
            if (!in_win_v || hvsync_hpos[8]) begin
                pix_d = OUTSIDE_PIX;
            end else if (valid_q[front_q]) begin
                pix_d = buf_mem[front_q][rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= 7'd0;
            row_q      <= 6'd0;
            mode_q     <= 1'b0;
            front_q    <= 1'b0;
            valid_q    <= 2'b00;
            underrun_q <= 1'b0;
            wr_en_q    <= 1'b0;
            pix_q      <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            wr_en_q <= (state_q == FETCH) && !abort;
            pix_q   <= pix_d;
            if ((hvsync_hpos == 9'd0) && (hvsync_vpos == 9'd0)) begin
                mode_q <= hires;
            end
            if (swap) begin
                front_q <= ~front_q;
            end
            if (abort) begin
                underrun_q <= 1'b1;
            end
        end
    end

    // Buffer contents are never reset; the valid bits mask stale data.
    always_ff @(posedge clk) begin
        wr_col_q <= col_q;
        if (wr_en_q && !reset) begin
            buf_mem[~front_q][wr_col_q] <= vram_pixel;
        end
    end

    assign vram_hpos    = (state_q == FETCH) ? col_q : 7'd0;
    assign vram_vpos    = (state_q == FETCH) ? row_q : 6'd0;
    assign fetch_busy   = (state_q != IDLE);
    assign underrun     = underrun_q;
    assign hvsync_pixel = pix_q;

endmodule

// File: tb/tb_vdrive_linebuf.sv
// Bench for vdrive_linebuf: drives beam lines, models VRAM, and checks every output cycle against a line-level reference.
module tb_vdrive_linebuf;

    localparam int V_OFS  = 56;
    localparam int H_END  = 256;
    localparam int BORDER = 2;
`ifdef VDRIVE_BORDER_EN
    localparam int OUT_EXP = BORDER;
`else
    localparam int OUT_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, hires, display_on;
    logic [8:0] hpos, vpos;
    logic [6:0] vram_hpos;
    logic [5:0] vram_vpos;
    logic [1:0] vram_pixel;
    logic [1:0] hvsync_pixel;
    logic       fetch_busy, underrun;

    always #5 clk = ~clk;

    vdrive_linebuf #(
        .PLANES(2), .H_END(H_END), .V_OFS(V_OFS), .BORDER(BORDER)
    ) dut (
        .clk(clk), .reset(reset), .hires(hires),
        .hvsync_hpos(hpos), .hvsync_vpos(vpos), .display_on(display_on),
        .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixel(vram_pixel),
        .hvsync_pixel(hvsync_pixel), .fetch_busy(fetch_busy), .underrun(underrun)
    );

    logic [1:0] vram [0:63][0:127];
    always @(posedge clk) vram_pixel <= vram[vram_vpos][vram_hpos];

    int n_assert = 0;
    int n_fail   = 0;
    int cur_v, cur_h;

    // Reference state: remaining busy cycles of the current fetch and which rows each buffer holds.
    int m_mode = 0, m_busy = 0, m_fn = 64, m_frow = 0;
    int m_back_valid = 0, m_back_row = 0, m_front_valid = 0, m_front_row = 0;
    int m_underrun = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s v=%0d h=%0d observed=%0d expected=%0d", tag, cur_v, cur_h, obs, exp);
        end
    endtask

    function automatic int ref_pix(input int h, input int v, input bit de);
        int s;
        s = m_mode ? 1 : 2;
        if (!de) return 0;
        if (v < V_OFS || v > V_OFS + 127 || h >= ((m_mode ? 128 : 64) << s)) return OUT_EXP;
        if (!m_front_valid) return 0;
        return int'(vram[m_front_row][h >> s]);
    endfunction

    task automatic step(input int h, input int v, input bit de, input bit rst);
        int exp_pix;
        hpos = 9'(h); vpos = 9'(v); display_on = de; reset = rst;
        cur_h = h; cur_v = v;
        exp_pix = rst ? 0 : ref_pix(h, v, de);
        if (rst) begin
            m_mode = 0; m_busy = 0; m_back_valid = 0; m_front_valid = 0; m_underrun = 0;
        end else begin
            if (h == H_END) begin
                if (m_busy > 0) begin
                    m_underrun = 1;
                    m_busy = 0;
                end
                m_front_valid = m_back_valid;
                m_front_row   = m_back_row;
                m_back_valid  = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_back_valid = 1;
                    m_back_row   = m_frow;
                end
            end else if (h == 0 && v + 1 >= V_OFS && v + 1 <= V_OFS + 127) begin
                m_fn   = m_mode ? 128 : 64;
                m_busy = m_fn + 1;
                m_frow = (v + 1 - V_OFS) >> (m_mode ? 1 : 2);
            end
            if (h == 0 && v == 0) m_mode = hires;
        end
        @(posedge clk);
        #1;
        chk("pixel", 32'(hvsync_pixel), 32'(exp_pix));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_busy > 0));
        chk("underrun", 32'(underrun), 32'(m_underrun));
        if (m_busy >= 2) begin
            chk("vram_hpos", 32'(vram_hpos), 32'(m_fn + 1 - m_busy));
            chk("vram_vpos", 32'(vram_vpos), 32'(m_frow));
        end else if (m_busy == 0) begin
            chk("vram_hpos_idle", 32'(vram_hpos), 32'd0);
            chk("vram_vpos_idle", 32'(vram_vpos), 32'd0);
        end
    endtask

    // One beam line: hpos 0..len-1, then jump to H_END..H_END+3 (contiguous when len==256).
    task automatic run_line(input int v, input int len, input bit rnd_de);
        int  busy_cnt;
        bit  started;
        busy_cnt = 0;
        started  = 1'b0;
        for (int h = 0; h < len; h++) begin
            step(h, v, rnd_de ? 1'($urandom_range(0, 1)) : (h < 256), 1'b0);
            if (h == 0) started = (m_busy > 0);
            busy_cnt += int'(fetch_busy);
        end
        for (int h = H_END; h < H_END + 4; h++) begin
            step(h, v, rnd_de ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
            busy_cnt += int'(fetch_busy);
        end
        if (started && len == 256) chk("busy_clks", 32'(busy_cnt), 32'(m_fn + 1));
    endtask

    initial begin
        reset = 1'b1; hires = 1'b0; display_on = 1'b0; hpos = '0; vpos = '0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++) vram[r][c] = 2'b00;

        step(0, 0, 1'b0, 1'b1);
        step(5, 60, 1'b1, 1'b1);

        // Lo-res single lit pixel at column 5, row 3.
        vram[3][5] = 2'b11;
        hires = 1'b0;
        run_line(0, 256, 1'b0);
        for (int v = 66; v <= 72; v++) run_line(v, 256, 1'b0);
        run_line(10, 256, 1'b1);

        // Hi-res with random contents, window top and bottom edges.
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++) vram[r][c] = 2'($urandom_range(0, 3));
        vram[63][127] = 2'b01;
        hires = 1'b1;
        run_line(0, 256, 1'b0);
        for (int v = 54; v <= 58; v++) run_line(v, 256, 1'b0);
        for (int v = 180; v <= 184; v++) run_line(v, 256, 1'b0);

        // Mode change mid-frame only lands at the next frame start.
        run_line(99, 256, 1'b0);
        hires = 1'b0;
        run_line(100, 256, 1'b0);
        run_line(101, 256, 1'b0);
        run_line(0, 256, 1'b0);
        for (int v = 99; v <= 101; v++) run_line(v, 256, 1'b0);
        run_line(102, 256, 1'b1);

        // Swap forced during a hi-res fetch.
        hires = 1'b1;
        run_line(0, 256, 1'b0);
        run_line(120, 256, 1'b0);
        run_line(121, 41, 1'b0);
        run_line(122, 256, 1'b0);
        run_line(123, 256, 1'b0);
        step(0, 0, 1'b0, 1'b1);

        // Reset while column 40 is on the address bus.
        hires = 1'b0;
        run_line(79, 256, 1'b0);
        for (int h = 0; h <= 40; h++) step(h, 80, 1'b1, 1'b0);
        chk("addr_at_c40", 32'(vram_hpos), 32'd40);
        step(41, 80, 1'b1, 1'b1);
        for (int h = 42; h < 260; h++) step(h, 80, h < 256, 1'b0);
        run_line(81, 256, 1'b0);
        run_line(82, 256, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
